// File: rtl/updown_mod_counter.sv
// Up/down modulo-N counter with variable step, parallel load and wrap or saturate mode.
// The arithmetic is one bit wider than the count, so modulus = 2**width cannot silently truncate.
module updown_mod_counter #(
  parameter int width    = 8,
  parameter int modulus  = 256,
  parameter bit sat_mode = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic [width-1:0] step,
  input  logic             load,
  input  logic [width-1:0] load_val,
  output logic [width-1:0] cnt,
  output logic             ovf,
  output logic             at_max,
  output logic             at_min
);

  localparam int               W1    = width + 1;
  localparam logic [W1-1:0]    MOD_W = W1'(modulus);
  localparam logic [W1-1:0]    TOP_W = W1'(modulus - 1);
  localparam logic [width-1:0] TOP_N = width'(modulus - 1);

  logic [width-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [W1-1:0]    cnt_x, step_x, load_x, s_x, sum_x, nxt_x;

  // Next-state: load beats count; count uses the step clamped to modulus-1.
  always_comb begin
    cnt_x  = {1'b0, cnt_q};
    step_x = {1'b0, step};
    load_x = {1'b0, load_val};
    s_x    = (step_x > TOP_W) ? TOP_W : step_x;
    sum_x  = cnt_x + s_x;
    nxt_x  = cnt_x;
    ovf_d  = 1'b0;
    if (load) begin
      nxt_x = (load_x > TOP_W) ? TOP_W : load_x;
    end else if (en) begin
      if (dir) begin
        if (sum_x <= TOP_W) begin
          nxt_x = sum_x;
        end else if (sat_mode) begin
          nxt_x = TOP_W;
          ovf_d = 1'b1;
        end else begin
          nxt_x = sum_x - MOD_W;
          ovf_d = 1'b1;
        end
      end else begin
        if (cnt_x >= s_x) begin
          nxt_x = cnt_x - s_x;
        end else if (sat_mode) begin
          nxt_x = {W1{1'b0}};
          ovf_d = 1'b1;
        end else begin
          nxt_x = cnt_x + (MOD_W - s_x);
          ovf_d = 1'b1;
        end
      end
    end else begin
      nxt_x = cnt_x;
    end
    cnt_d = width'(nxt_x);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {width{1'b0}};
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt    = cnt_q;
  assign ovf    = ovf_q;
  assign at_max = (cnt_q == TOP_N);
  assign at_min = (cnt_q == {width{1'b0}});

endmodule
